// File: rtl/reg_file_param.sv
// Register file: one write port, two synchronous read ports, hardware clear after reset.
// Optional same-cycle write-to-read bypass enabled by defining REG_FILE_BYPASS_EN.
module reg_file_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  output logic              ready,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr0,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data0,
  output logic [DATA_W-1:0] rd_data1,
  output logic              rd_valid
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] rd_data0_q, rd_data0_d;
  logic [DATA_W-1:0] rd_data1_q, rd_data1_d;
  logic              rd_valid_q, rd_valid_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_waddr_c;
  logic [DATA_W-1:0] mem_wdata_c;
  logic              wr_drop_c;
  logic              zero0_c, zero1_c;
  logic              byp0_c, byp1_c;
  logic [DATA_W-1:0] rd_val0_c, rd_val1_c;

  assign wr_drop_c = (ZERO_REG != 0) && (wr_addr == '0);
  assign zero0_c   = (ZERO_REG != 0) && (rd_addr0 == '0);
  assign zero1_c   = (ZERO_REG != 0) && (rd_addr1 == '0);

`ifdef REG_FILE_BYPASS_EN
  // Forward the in-flight write so readers see it in the same cycle.
  assign byp0_c = wr_en && !wr_drop_c && (wr_addr == rd_addr0);
  assign byp1_c = wr_en && !wr_drop_c && (wr_addr == rd_addr1);
`else
  assign byp0_c = 1'b0;
  assign byp1_c = 1'b0;
`endif

  assign rd_val0_c = zero0_c ? '0 : (byp0_c ? wr_data : mem_q[rd_addr0]);
  assign rd_val1_c = zero1_c ? '0 : (byp1_c ? wr_data : mem_q[rd_addr1]);

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ready_d     = ready_q;
    rd_data0_d  = rd_data0_q;
    rd_data1_d  = rd_data1_q;
    rd_valid_d  = 1'b0;
    mem_we_c    = 1'b0;
    mem_waddr_c = cnt_q;
    mem_wdata_c = '0;

    case (state_q)
      ST_CLEAR: begin
        mem_we_c    = 1'b1;
        mem_waddr_c = cnt_q;
        mem_wdata_c = '0;
        cnt_d       = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        mem_we_c    = wr_en && !wr_drop_c;
        mem_waddr_c = wr_addr;
        mem_wdata_c = wr_data;
        if (rd_en) begin
          rd_data0_d = rd_val0_c;
          rd_data1_d = rd_val1_c;
          rd_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      rd_data0_q <= '0;
      rd_data1_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      rd_data0_q <= rd_data0_d;
      rd_data1_q <= rd_data1_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Storage has no reset; the clear sequence defines its contents.
  always_ff @(posedge clk) begin
    if (mem_we_c) mem_q[mem_waddr_c] <= mem_wdata_c;
  end

  assign ready    = ready_q;
  assign rd_data0 = rd_data0_q;
  assign rd_data1 = rd_data1_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: doc/reg_file_param.md
# reg_file_param

Parametrised, synchronous-read register file for the pipelined processor core: one write port, two read ports, configurable data width and depth, and an optional hard-wired zero register. After reset it runs a hardware clear sequence, zeroing every entry one per cycle, and holds `ready` low until the sequence finishes. An optional same-cycle write-to-read bypass removes the need for a half-cycle negedge read scheme. It sits in the decode stage, with its write port driven from writeback.

## Interface
- `DATA_W`, 32, width of each register in bits.
- `ADDR_W`, 5, address width; `DEPTH = 2**ADDR_W` entries.
- `ZERO_REG`, 1, when 1, entry 0 always reads 0 and writes to it are dropped.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `ready`  out  1  high once the clear sequence completes.
- `wr_en`  in  1  write strobe.
- `wr_addr`  in  ADDR_W  write address.
- `wr_data`  in  DATA_W  write data.
- `rd_en`  in  1  read strobe, shared by both read ports.
- `rd_addr0`  in  ADDR_W  read address, port 0.
- `rd_addr1`  in  ADDR_W  read address, port 1.
- `rd_data0`  out  DATA_W  registered read data, port 0.
- `rd_data1`  out  DATA_W  registered read data, port 1.
- `rd_valid`  out  1  high for one cycle when `rd_data0`/`rd_data1` were updated by a read.

## Operation
- FSM states: CLEAR and RUN.
- While `reset` is high, the block is held in CLEAR with: clear counter = 0, `ready` = 0, `rd_valid` = 0, `rd_data0` = 0, `rd_data1` = 0.
- CLEAR: each rising edge writes 0 to entry[counter], then increments the counter.
  - When counter = DEPTH-1, that entry is cleared, the FSM moves to RUN, and `ready` = 1 from the next cycle.
  - The clear takes DEPTH cycles in total.
  - `wr_en` and `rd_en` are ignored in CLEAR; `rd_valid` stays 0.
- RUN, write: `wr_en` = 1 writes `wr_data` to entry[`wr_addr`] at the edge.
  - If `ZERO_REG` = 1 and `wr_addr` = 0, the write is dropped.
- RUN, read: `rd_en` = 1 samples entry[`rd_addrN`] into `rd_dataN` at the edge, and `rd_valid` = 1 for the following cycle.
  - If `ZERO_REG` = 1 and `rd_addrN` = 0, `rd_dataN` = 0.
  - `rd_en` = 0: `rd_data0`/`rd_data1` hold their previous values, and `rd_valid` = 0.
- Simultaneous read and write to the same address: governed by the bypass configuration (see Configuration).
- Both read ports may address the same entry; each returns the same value.
- Reset asserted mid-sequence or mid-operation: immediate return to CLEAR, and the full clear restarts after deassert.
  - Register contents are not guaranteed until `ready` = 1.

## Timing
- Read latency is 1 cycle: address and `rd_en` are sampled at edge N; data and `rd_valid` are valid after edge N.
- Write latency is 1 cycle: the value is visible to a read sampled at edge N+1, or at edge N when bypass is enabled.
- `ready` rises DEPTH rising edges after `reset` deasserts (32 for the defaults).
- Throughput: one write plus two reads every cycle, with no stalls in RUN.

## Configuration
- Macro `REG_FILE_BYPASS_EN`, defined: a read in the same cycle as a write to the same address (non-zero address, or any address when `ZERO_REG` = 0) returns `wr_data` on that port.
- Macro `REG_FILE_BYPASS_EN`, undefined: that read returns the entry's old value, and the new value is visible from the next read onward.

## Test plan
- Reset clear: assert `reset` for 3 cycles, then release -> `ready` = 0 for exactly 32 edges, then 1. Reading addresses 0–31 with `rd_en` = 1 returns 0 on both ports, with `rd_valid` = 1 one cycle after each read.
- Write/read: write 0xDEADBEEF to address 7, then read `rd_addr0` = 7, `rd_addr1` = 7 the next cycle -> both ports return 0xDEADBEEF one cycle later.
- Zero register: write 0x12345678 to address 0, then read address 0 -> returns 0. Repeat with `ZERO_REG` = 0 -> returns 0x12345678.
- Same-cycle hazard: address 5 holds 0x11; in one cycle write 0x22 to address 5 with `rd_addr0` = 5 -> returns 0x22 with `REG_FILE_BYPASS_EN` defined, 0x11 without.
- Reset mid-clear and ignored accesses: assert `reset` at counter = 10 -> `ready` stays 0 for a fresh 32 edges. A `wr_en` issued during CLEAR leaves the target entry at 0 after `ready` rises.
- Read hold: read address 3 (value 0x33), then drop `rd_en` and change `rd_addr0` -> `rd_data0` stays 0x33 and `rd_valid` = 0.
